// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the 16-bit data memory: turns load/store/stack ops into
// one- or two-word memory transactions, owns the stack pointer and stalls the pipeline.
module mem_access_unit #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned STACK_TOP   = 2047,
  parameter int unsigned STACK_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  op,
  input  logic [31:0] ea,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        stack_fault,
  output logic [31:0] sp,
  output logic [31:0] mem_address,
  output logic [15:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_cs,
  input  logic [15:0] mem_read_data
);

  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;
  localparam logic [2:0] OP_CALL  = 3'd5;
  localparam logic [2:0] OP_RET   = 3'd6;

  localparam logic [ADDR_W:0] TOP_W = (ADDR_W+1)'(STACK_TOP);
  localparam logic [ADDR_W:0] LIM_W = (ADDR_W+1)'(STACK_LIMIT);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [31:0]         wd_q;
  logic [ADDR_W-1:0]   sp_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         lo_q;

  logic                valid_op_c;
  logic                is_read_c;
  logic                fault_c;
  logic [ADDR_W:0]     sp_w;
  logic [ADDR_W-1:0]   sp_p1, sp_p2, sp_m1, sp_m2;
  logic [ADDR_W-1:0]   a1_addr_c;
  logic [15:0]         a1_wdata_c;
  logic                a1_write_c;
  logic                unused_ea;

  assign unused_ea   = ^ea[31:ADDR_W];
  assign valid_op_c  = (op != 3'd0) && (op != 3'd7);
  assign is_read_c   = (op == OP_LOAD) || (op == OP_POP) || (op == OP_RET);
  assign sp_w        = {1'b0, sp_q};
  assign sp_p1       = sp_q + ADDR_W'(1);
  assign sp_p2       = sp_q + ADDR_W'(2);
  assign sp_m1       = sp_q - ADDR_W'(1);
  assign sp_m2       = sp_q - ADDR_W'(2);

  assign busy        = (state == ACC1) || (state == ACC2) ||
                       ((state == IDLE) && req_valid && valid_op_c);
  assign sp          = {(32-ADDR_W)'(0), sp_q};
  assign mem_address = {(32-ADDR_W)'(0), addr_q};

  // Stack bounds checked against the current SP before any access is issued
  always_comb begin
    fault_c = 1'b0;
    case (op)
      OP_PUSH: fault_c = sp_w < LIM_W;
      OP_CALL: fault_c = sp_w < (LIM_W + (ADDR_W+1)'(1));
      OP_POP:  fault_c = sp_w == TOP_W;
      OP_RET:  fault_c = (sp_w + (ADDR_W+1)'(2)) > TOP_W;
      default: fault_c = 1'b0;
    endcase
  end

  // First-word address/data for the incoming op
  always_comb begin
    a1_addr_c  = ea[ADDR_W-1:0];
    a1_wdata_c = wdata[15:0];
    a1_write_c = 1'b0;
    case (op)
      OP_STORE: a1_write_c = 1'b1;
      OP_PUSH:  begin a1_addr_c = sp_q; a1_write_c = 1'b1; end
      OP_POP,
      OP_RET:   a1_addr_c = sp_p1;
      OP_CALL:  begin a1_addr_c = sp_q; a1_wdata_c = wdata[31:16]; a1_write_c = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      op_q           <= 3'd0;
      wd_q           <= 32'd0;
      sp_q           <= ADDR_W'(STACK_TOP);
      addr_q         <= '0;
      lo_q           <= 16'd0;
      rdata          <= 32'd0;
      rdata_valid    <= 1'b0;
      stack_fault    <= 1'b0;
      mem_write_data <= 16'd0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_cs         <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && valid_op_c) begin
            op_q <= op;
            wd_q <= wdata;
            if (fault_c) begin
              stack_fault <= 1'b1;
              rdata       <= 32'd0;
              rdata_valid <= is_read_c;
              state       <= DONE;
            end else begin
              addr_q         <= a1_addr_c;
              mem_write_data <= a1_wdata_c;
              mem_write      <= a1_write_c;
              mem_read       <= ~a1_write_c;
              mem_cs         <= 1'b1;
              state          <= ACC1;
            end
          end
        end
        ACC1: begin
          if (op_q == OP_CALL || op_q == OP_RET) begin
            // Second word sits below SP for CALL, above the low word for RET
            lo_q           <= mem_read_data;
            addr_q         <= (op_q == OP_CALL) ? sp_m1 : sp_p2;
            mem_write_data <= wd_q[15:0];
            state          <= ACC2;
          end else begin
            mem_cs    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            addr_q    <= '0;
            mem_write_data <= 16'd0;
            if (op_q == OP_LOAD || op_q == OP_POP) begin
              rdata       <= {16'd0, mem_read_data};
              rdata_valid <= 1'b1;
            end
            if (op_q == OP_PUSH) sp_q <= sp_m1;
            if (op_q == OP_POP)  sp_q <= sp_p1;
            state <= DONE;
          end
        end
        ACC2: begin
          mem_cs         <= 1'b0;
          mem_read       <= 1'b0;
          mem_write      <= 1'b0;
          addr_q         <= '0;
          mem_write_data <= 16'd0;
          if (op_q == OP_RET) begin
            rdata       <= {mem_read_data, lo_q};
            rdata_valid <= 1'b1;
            sp_q        <= sp_p2;
          end else begin
            sp_q <= sp_m2;
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural memory and a read-data scoreboard.
module tb_mem_access_unit;

  localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_STORE = 3'd2, OP_PUSH = 3'd3,
                         OP_POP = 3'd4, OP_CALL = 3'd5, OP_RET = 3'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  op;
  logic [31:0] ea, wdata;
  logic        busy, rdata_valid, stack_fault;
  logic [31:0] rdata, sp, mem_address;
  logic [15:0] mem_write_data, mem_read_data;
  logic        mem_read, mem_write, mem_cs;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [15:0] mem [0:2047];
  logic [15:0] saved;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .op(op), .ea(ea), .wdata(wdata),
    .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid), .stack_fault(stack_fault),
    .sp(sp), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_cs(mem_cs),
    .mem_read_data(mem_read_data)
  );

  // Synchronous-write, level-sensitive-read memory
  always @(posedge clk)
    if (mem_cs && mem_write) mem[mem_address[10:0]] <= mem_write_data;
  assign mem_read_data = (mem_cs && mem_read) ? mem[mem_address[10:0]] : 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: read results against the scoreboard, plus bus sanity every cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (rdata_valid) begin
        if (exp_q.size() == 0) chk("unexpected rdata_valid", 32'd1, 32'd0);
        else chk("rdata", rdata, exp_q.pop_front());
      end
      if (mem_read && mem_write) chk("read_and_write", 32'd1, 32'd0);
      if (mem_address[31:11] != 21'd0) chk("addr_upper", mem_address, {21'd0, mem_address[10:0]});
    end
  end

  // Issue one op, hold it while busy; checks latency and number of memory cycles
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                       input int exp_lat, input int exp_cs, input logic exp_rd,
                       input logic [31:0] exp_data);
    int n;
    int ncs;
    bit done;
    n = 0; ncs = 0; done = 0;
    if (exp_rd) exp_q.push_back(exp_data);
    req_valid = 1'b1; op = o; ea = a; wdata = d;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (mem_cs) ncs++;
      if (busy) n++;
      else begin
        done = 1;
        chk("rdata_valid_at_done", 32'(rdata_valid), 32'(exp_rd));
      end
    end
    if (!done) chk("busy_timeout", 32'd1, 32'd0);
    chk("latency", n, exp_lat);
    chk("mem_cycles", ncs, exp_cs);
    @(posedge clk); #1;
    req_valid = 1'b0; op = OP_NOP;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; op = OP_NOP;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    ea = 32'd0; wdata = 32'd0;
    do_reset();
    chk("reset_sp", sp, 32'd2047);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cs", 32'(mem_cs), 32'd0);
    chk("reset_fault", 32'(stack_fault), 32'd0);
    chk("reset_rdata", rdata, 32'd0);

    // NOP and reserved op are ignored
    req_valid = 1'b1; op = 3'd7; #1;
    chk("reserved_busy", 32'(busy), 32'd0);
    op = OP_NOP; #1;
    chk("nop_busy", 32'(busy), 32'd0);
    req_valid = 1'b0;

    // Reset during CALL's first access aborts at once
    saved = mem[2047];
    req_valid = 1'b1; op = OP_CALL; wdata = 32'hDEAD0001;
    @(posedge clk); #1;
    chk("call_acc1_write", 32'(mem_write), 32'd1);
    rst = 1'b1; req_valid = 1'b0; op = OP_NOP; #1;
    chk("abort_write", 32'(mem_write), 32'd0);
    chk("abort_cs", 32'(mem_cs), 32'd0);
    chk("abort_sp", sp, 32'd2047);
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_no_write", 32'(mem[2047]), 32'(saved));

    do_op(OP_STORE, 32'h0000_0005, 32'h0000_BEEF, 2, 1, 1'b0, 32'd0);
    chk("store_mem5", 32'(mem[5]), 32'h0000_BEEF);
    do_op(OP_LOAD, 32'h0000_0005, 32'd0, 2, 1, 1'b1, 32'h0000_BEEF);
    do_op(OP_LOAD, 32'hFFFF_0805, 32'd0, 2, 1, 1'b1, 32'h0000_BEEF);

    do_op(OP_PUSH, 32'd0, 32'h0000_1234, 2, 1, 1'b0, 32'd0);
    do_op(OP_PUSH, 32'd0, 32'h0000_5678, 2, 1, 1'b0, 32'd0);
    chk("push_sp", sp, 32'd2045);
    chk("push_mem2046", 32'(mem[2046]), 32'h5678);
    do_op(OP_POP, 32'd0, 32'd0, 2, 1, 1'b1, 32'h0000_5678);
    do_op(OP_POP, 32'd0, 32'd0, 2, 1, 1'b1, 32'h0000_1234);
    chk("pop_sp", sp, 32'd2047);

    do_op(OP_CALL, 32'd0, 32'hCAFE_0042, 3, 2, 1'b0, 32'd0);
    chk("call_hi", 32'(mem[2047]), 32'h0000_CAFE);
    chk("call_lo", 32'(mem[2046]), 32'h0000_0042);
    chk("call_sp", sp, 32'd2045);
    do_op(OP_RET, 32'd0, 32'd0, 3, 2, 1'b1, 32'hCAFE_0042);
    chk("ret_sp", sp, 32'd2047);

    // Back-to-back ops with the request held across busy
    do_op(OP_STORE, 32'h0000_0006, 32'h0000_1111, 2, 1, 1'b0, 32'd0);
    do_op(OP_LOAD,  32'h0000_0006, 32'd0,         2, 1, 1'b1, 32'h0000_1111);
    do_op(OP_LOAD,  32'h0000_0005, 32'd0,         2, 1, 1'b1, 32'h0000_BEEF);
    do_op(OP_CALL,  32'd0,         32'h0102_0304, 3, 2, 1'b0, 32'd0);
    do_op(OP_RET,   32'd0,         32'd0,         3, 2, 1'b1, 32'h0102_0304);

    // Underflow: POP and RET at the top of stack
    chk("pre_underflow_fault", 32'(stack_fault), 32'd0);
    do_op(OP_POP, 32'd0, 32'd0, 1, 0, 1'b1, 32'd0);
    chk("underflow_fault", 32'(stack_fault), 32'd1);
    chk("underflow_sp", sp, 32'd2047);
    do_op(OP_RET, 32'd0, 32'd0, 1, 0, 1'b1, 32'd0);
    chk("ret_underflow_sp", sp, 32'd2047);
    do_op(OP_LOAD, 32'h0000_0005, 32'd0, 2, 1, 1'b1, 32'h0000_BEEF);
    chk("fault_sticky", 32'(stack_fault), 32'd1);

    // Overflow: fill down to the limit, then one more PUSH
    do_reset();
    chk("reset_clears_fault", 32'(stack_fault), 32'd0);
    for (int i = 0; i < 1024; i++) do_op(OP_PUSH, 32'd0, 32'(i), 2, 1, 1'b0, 32'd0);
    chk("full_sp", sp, 32'd1023);
    chk("full_fault", 32'(stack_fault), 32'd0);
    chk("limit_word", 32'(mem[1024]), 32'd1023);
    saved = mem[1023];
    do_op(OP_PUSH, 32'd0, 32'h0000_ABCD, 1, 0, 1'b0, 32'd0);
    chk("overflow_fault", 32'(stack_fault), 32'd1);
    chk("overflow_sp", sp, 32'd1023);
    chk("overflow_no_write", 32'(mem[1023]), 32'(saved));
    do_op(OP_POP, 32'd0, 32'd0, 2, 1, 1'b1, 32'd1023);
    chk("pop_after_overflow_sp", sp, 32'd1024);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the 16-bit-word data memory (2^11 words, 11-bit word address, synchronous write, level-sensitive read).
- Converts pipeline memory ops (load, store, push, pop, call, ret) into single- or double-word memory transactions.
- Owns the stack pointer and stalls the pipeline while a transaction is in flight.

Parameters:
- ADDR_W, 11, significant word-address bits driven to memory (upper mem_address bits forced 0)
- STACK_TOP, 2047, SP reset value (2^11-1); stack grows downward
- STACK_LIMIT, 1024, lowest legal stack word; pushes below it fault

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM-stage request present
- op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET, 7 reserved (treated as NOP)
- ea  in  32  effective address for LOAD/STORE
- wdata  in  32  STORE/PUSH use [15:0]; CALL uses full 32-bit return PC
- busy  out  1  stall request to pipeline
- rdata  out  32  LOAD/POP: {16'b0, word}; RET: {high, low}
- rdata_valid  out  1  one-cycle pulse, rdata valid
- stack_fault  out  1  sticky overflow/underflow flag
- sp  out  32  current stack pointer, zero-extended
- mem_address  out  32  to memory address
- mem_write_data  out  16  to memory writeData
- mem_read  out  1  to memory read
- mem_write  out  1  to memory write
- mem_cs  out  1  to memory CS
- mem_read_data  in  16  from memory readData

Behaviour:
- Reset (async): state IDLE, sp=STACK_TOP, busy=0, rdata=0, rdata_valid=0, stack_fault=0, all mem_* outputs 0.
- States: IDLE, ACC1, ACC2, DONE.
- IDLE: busy=0. On rising edge with req_valid=1 and op in 1..6, latch op/ea/wdata, go ACC1. NOP/reserved ignored.
- ACC1: mem_cs=1, busy=1. Exactly one of mem_read/mem_write is high; both are never high together.
  - Address and data per op:
    - LOAD: address = ea[10:0], read.
    - STORE: address = ea[10:0], write wdata[15:0].
    - PUSH: address = sp, write wdata[15:0].
    - POP: address = sp+1, read.
    - CALL: address = sp, write wdata[31:16].
    - RET: address = sp+1, read.
  - Read data is captured from mem_read_data on the edge leaving ACC1.
  - Next state: CALL/RET go to ACC2; all other ops go to DONE.
- ACC2:
  - CALL: address = sp-1, write wdata[15:0].
  - RET: address = sp+2, read; high word captured.
  - Next state: DONE.
- DONE: mem_* outputs = 0, busy=0.
  - rdata_valid=1 for LOAD, POP, RET.
  - sp update: PUSH -1, POP +1, CALL -2, RET +2.
  - Return to IDLE next edge; a new request is not accepted in DONE.
- Latency, accept edge to rdata_valid: 2 cycles for single-word ops, 3 for CALL/RET.
- Throughput: one op per 3 cycles (single-word), 4 cycles (double-word).
- busy is asserted combinationally in IDLE whenever req_valid=1 with a valid op. The pipeline holds its request until busy falls.
- Fault rules:
  - PUSH with sp < STACK_LIMIT, or CALL with sp-1 < STACK_LIMIT: overflow.
  - POP with sp = STACK_TOP, or RET with sp+2 > STACK_TOP: underflow.
  - On fault: no memory access, sp unchanged, stack_fault set.
  - Faulting op goes IDLE→DONE (rdata=0, rdata_valid pulses for reads).
  - stack_fault clears only on reset.
- sp arithmetic is ADDR_W bits; legal ops never wrap.
- LOAD/STORE ignore ea[31:11].
- Reset mid-transaction: immediate abort, mem_* drop to 0 asynchronously, no partial sp update. A half-done CALL may leave one word written.

Test Plan:
- Reset -> sp=2047, busy=0, mem_cs=0, stack_fault=0; assert rst mid-CALL ACC1 -> mem_write=0 at once, sp=2047.
- STORE ea=0x0005 wdata=0xBEEF, then LOAD ea=0x0005 -> rdata=0x0000BEEF, rdata_valid 2 cycles after accept; LOAD ea=0xFFFF0805 aliases word 5.
- PUSH 0x1234, PUSH 0x5678 -> sp=2045; POP -> 0x5678, POP -> 0x1234, sp=2047.
- CALL wdata=0xCAFE0042 -> mem[2047]=0xCAFE, mem[2046]=0x0042, sp=2045; RET -> rdata=0xCAFE0042, sp=2047, latency 3.
- POP at sp=2047 -> stack_fault=1, no mem_cs, sp=2047; PUSH with sp=1023 -> fault, no write.
- req_valid held through busy with back-to-back ops -> each accepted once, mem_read & mem_write never both 1.
